// File: rtl/button_debouncer.sv
// button_debouncer
//   Debounces one synchronized push-button level. A new level is accepted only
//   after STABLE_CYCLES consecutive identical samples; any opposite sample while
//   qualifying restarts from zero. Outputs a registered clean level, a one-cycle
//   press pulse on each accepted 0->1 transition, and a busy flag while a
//   candidate transition is being qualified.
//   Optional feature macro: DEBOUNCE_RELEASE_PULSE_EN adds release_pulse, a
//   one-cycle pulse on each accepted 1->0 transition.
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic press_pulse,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  output logic release_pulse,
`endif
  output logic busy
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal count: the qualifying sample that arrives with the counter here
  // completes the run of STABLE_CYCLES identical samples.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_d;
  logic                 release_d;

  // Next-state, next-counter and pulse decode.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (in) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!in) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!in) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (in) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output flops decoded from the next state, so they change on the same edge
  // as the state and never see a combinational path from in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= 1'b0;
      busy        <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      level       <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      busy        <= (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
      press_pulse <= press_d;
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  // One-cycle pulse on an accepted release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) release_pulse <= 1'b0;
    else        release_pulse <= release_d;
  end
`else
  // release_d only feeds the optional release pulse flop.
  logic unused_release;
  assign unused_release = release_d;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Directed bench for button_debouncer with STABLE_CYCLES=4. A table of
//   {in, expected outputs} records is applied one clock at a time, followed by
//   hand-written sequences for reset and glitch corner cases. Inputs change and
//   outputs are sampled 1 ns after the rising edge.
module tb_button_debouncer;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in;
  logic level, press_pulse, busy;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic release_pulse;
`endif

  int tests  = 0;
  int failed = 0;

  button_debouncer #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .level       (level),
    .press_pulse (press_pulse),
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    .release_pulse (release_pulse),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in;
    logic lvl;
    logic pls;
    logic bsy;
    logic rel;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive in, advance one rising edge, land 1 ns after it.
  task automatic tick(input logic v);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic l, input logic p, input logic b);
    check({tag, " level"}, level, l);
    check({tag, " press_pulse"}, press_pulse, p);
    check({tag, " busy"}, busy, b);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    in    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Release rst_n with in held high; expect a fresh full qualification.
  task automatic qualify_press(input string tag);
    for (int i = 1; i <= STABLE; i++) begin
      tick(1'b1);
      check_outs($sformatf("%s e%0d", tag, i), (i == STABLE), (i == STABLE), (i < STABLE));
    end
    tick(1'b1);
    check_outs({tag, " hold"}, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;

    // ---- Test 1: reset held with in=1, outputs stay 0; release qualifies ----
    in = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check_outs($sformatf("t1 rst%0d", i), 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    qualify_press("t1");

    // ---- Table-driven: press, release, glitches on both sides ----
    apply_reset();
    tick(1'b0);
    tick(1'b0);
    check_outs("idle", 1'b0, 1'b0, 1'b0);
    //           in    lvl   pls   bsy   rel
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}); // 0 press qualifying
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}); // 3 accepted
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // 4 pulse is one wide
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0}); // 5 release qualifying
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}); // 8 release accepted
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}); // 10 press glitch
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // 12 rejected
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}); // 13 restarts from zero
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}); // 16 accepted
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0}); // 17 release glitch
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // 19 back to pressed, no pulse
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0}); // 20 true release
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}); // 23 dropped
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].in);
      check_outs($sformatf("vec%0d", i), vq[i].lvl, vq[i].pls, vq[i].bsy);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      check($sformatf("vec%0d release_pulse", i), release_pulse, vq[i].rel);
`endif
    end

    // ---- Test 3: bouncing input never qualifies ----
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick(i[0] ? 1'b0 : 1'b1);
      check($sformatf("t3 bounce%0d level", i), level, 1'b0);
      check($sformatf("t3 bounce%0d press_pulse", i), press_pulse, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check($sformatf("t3 short%0d level", i), level, 1'b0);
      check($sformatf("t3 short%0d press_pulse", i), press_pulse, 1'b0);
    end
    tick(1'b0);
    check_outs("t3 end", 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    check_outs("t3 end2", 1'b0, 1'b0, 1'b0);

    // ---- Test 5: async reset mid-PRESS_WAIT, then fresh qualification ----
    apply_reset();
    tick(1'b1);
    tick(1'b1);
    check_outs("t5 waiting", 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outs("t5 async", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("t5 held", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    qualify_press("t5");

    // Async reset while pressed clears level immediately.
    #2 rst_n = 1'b0;
    #1 check("t5 pressed async level", level, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0);
    check_outs("t5 after", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
